// File: rtl/updown_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// updown_cnt_ctrl
//
// Purpose
//   Count source feeding the display scanner. Three raw push buttons are
//   synchronized and debounced. Their press events drive a STOP/UP/DOWN state
//   machine. While the machine is in UP or DOWN, a 16-bit prescaler produces
//   one count step every STEP_DIV clocks. The count runs over 0..MAX_CNT and
//   wraps in both directions. Each wrap emits a one-clock pulse and toggles
//   the LED.
//
// Parameters
//   STEP_DIV    clocks per count step               (2..65535)
//   DEB_CYCLES  stable clocks to accept a new level (2..255)
//   MAX_CNT     terminal count                      (1..255)
//
// Ports
//   clk       in   1  count/scan clock
//   rst_n     in   1  asynchronous reset, active low
//   btn_up    in   1  raw button, active high, asynchronous to clk
//   btn_down  in   1  raw button, active high, asynchronous to clk
//   btn_stop  in   1  raw button, active high, asynchronous to clk
//   cnt       out  8  current count, 0..MAX_CNT
//   dir       out  2  2'b10 UP, 2'b01 DOWN, 2'b00 STOP
//   wrap      out  1  one-clock pulse coincident with a wrapped count value
//   led       out  1  toggles on every wrap
// -----------------------------------------------------------------------------
module updown_cnt_ctrl #(
    parameter int unsigned STEP_DIV   = 1000,
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned MAX_CNT    = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_stop,
    output logic [7:0] cnt,
    output logic [1:0] dir,
    output logic       wrap,
    output logic       led
);

    // Bit positions of the three buttons inside the conditioning vectors.
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_STOP = 2;

    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);
    localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]  MAX_C     = 8'(MAX_CNT);

    // The state encodings match the dir output encoding.
    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_UP   = 2'b10,
        ST_DOWN = 2'b01
    } state_e;

    // ---------------------------------------------------------------------
    // Signals
    // ---------------------------------------------------------------------
    logic [2:0]      btn_raw_s;

    logic [2:0]      sync1_q,     sync1_d;
    logic [2:0]      sync2_q,     sync2_d;
    logic [2:0]      deb_level_q, deb_level_d;
    logic [2:0][7:0] deb_cnt_q,   deb_cnt_d;
    logic [2:0]      deb_prev_q,  deb_prev_d;
    logic [2:0]      press_q,     press_d;

    state_e          state_q,     state_d;
    logic            state_chg_s;

    logic [15:0]     presc_q,     presc_d;
    logic            step_s;

    logic [7:0]      cnt_q,       cnt_d;
    logic [1:0]      dir_q,       dir_d;
    logic            wrap_q,      wrap_d;
    logic            led_q,       led_d;

    assign btn_raw_s = {btn_stop, btn_down, btn_up};

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------

    // Two-stage synchronizer next-state for the raw buttons.
    always_comb begin
        sync1_d = btn_raw_s;
        sync2_d = sync1_q;
    end

    // Debounce: the accepted level flips only after the synced level has
    // differed from it on DEB_CYCLES consecutive clocks. The counter restarts
    // whenever the synced level agrees with the accepted level again.
    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_level_d[i] = sync2_q[i];
                    deb_cnt_d[i]   = 8'd0;
                end else begin
                    deb_cnt_d[i]   = deb_cnt_q[i] + 8'd1;
                end
            end else begin
                deb_cnt_d[i] = 8'd0;
            end
        end
    end

    // Press event: registered one-clock pulse on the rising edge of the
    // debounced level. A release produces no event.
    always_comb begin
        deb_prev_d = deb_level_q;
        press_d    = deb_level_q & ~deb_prev_q;
    end

    // ---------------------------------------------------------------------
    // Direction FSM
    // ---------------------------------------------------------------------

    // Next-state: stop wins outright. Up and down pressed together, without
    // stop, cancel each other and leave the state unchanged.
    always_comb begin
        state_d = state_q;
        if (press_q[BTN_STOP]) begin
            state_d = ST_STOP;
        end else if (press_q[BTN_UP] && !press_q[BTN_DOWN]) begin
            state_d = ST_UP;
        end else if (press_q[BTN_DOWN] && !press_q[BTN_UP]) begin
            state_d = ST_DOWN;
        end else begin
            state_d = state_q;
        end
        // A press for the current state is not a change, so it leaves the
        // prescaler running.
        state_chg_s = (state_d != state_q);
    end

    // ---------------------------------------------------------------------
    // Prescaler and count stepping
    // ---------------------------------------------------------------------

    // Prescaler: holds 0 in STOP and clears on every state change. It
    // discards any partial period, and a change on a terminal clock takes
    // precedence over the step.
    always_comb begin
        presc_d = presc_q;
        step_s  = 1'b0;
        if (state_chg_s) begin
            presc_d = 16'd0;
        end else begin
            case (state_q)
                ST_UP, ST_DOWN: begin
                    if (presc_q == STEP_LAST) begin
                        presc_d = 16'd0;
                        step_s  = 1'b1;
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                ST_STOP: presc_d = 16'd0;
                default: presc_d = 16'd0;
            endcase
        end
    end

    // Count, wrap pulse and LED. The upper bound uses >= so that an
    // out-of-range value can never persist.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        led_d  = led_q;
        if (step_s) begin
            if (state_q == ST_UP) begin
                if (cnt_q >= MAX_C) begin
                    cnt_d  = 8'd0;
                    wrap_d = 1'b1;
                    led_d  = ~led_q;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                end
            end else begin
                if (cnt_q == 8'd0) begin
                    cnt_d  = MAX_C;
                    wrap_d = 1'b1;
                    led_d  = ~led_q;
                end else begin
                    cnt_d  = cnt_q - 8'd1;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // dir is taken from the next state, so it updates on the same edge as
    // the state register.
    always_comb begin
        dir_d = state_d;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------

    // Synchronizer, debounce and press-event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
            deb_level_q <= 3'b000;
            deb_cnt_q   <= '0;
            deb_prev_q  <= 3'b000;
            press_q     <= 3'b000;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_prev_q  <= deb_prev_d;
            press_q     <= press_d;
        end
    end

    // FSM state and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            presc_q <= 16'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            dir_q  <= 2'b00;
            wrap_q <= 1'b0;
            led_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
        end
    end

    assign cnt  = cnt_q;
    assign dir  = dir_q;
    assign wrap = wrap_q;
    assign led  = led_q;

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_cnt_ctrl
//
// Directed bench for updown_cnt_ctrl with STEP_DIV=4, DEB_CYCLES=3 and
// MAX_CNT=99. Inputs change 1 time unit after a rising edge. Outputs are read
// at the same point, so the values seen after edge k are the values
// registered at edge k. A button set after edge E moves the FSM at edge E+7.
// -----------------------------------------------------------------------------
module tb_updown_cnt_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_stop;
    logic [7:0] cnt;
    logic [1:0] dir;
    logic       wrap;
    logic       led;

    int n_tests;
    int n_fail;
    int wrap_seen;
    int w0;

    updown_cnt_ctrl #(
        .STEP_DIV   (4),
        .DEB_CYCLES (3),
        .MAX_CNT    (99)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_stop (btn_stop),
        .cnt      (cnt),
        .dir      (dir),
        .wrap     (wrap),
        .led      (led)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the clocks on which wrap is high, sampling on the falling edge.
    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_seen++;
    end

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges. Return 1 unit after the last one.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        wrap_seen = 0;
        rst_n     = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_stop  = 1'b0;

        // 1. Reset held while the buttons toggle.
        for (int i = 0; i < 6; i++) begin
            btn_up   = i[0];
            btn_down = ~i[0];
            btn_stop = i[1];
            ticks(1);
            chk("rst_hold", 32'({cnt, dir, wrap, led}), 32'd0);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_stop = 1'b0;
        rst_n    = 1'b1;
        ticks(10);
        chk("rst_release", 32'({cnt, dir, wrap, led}), 32'd0);

        // 3. A 2-clock glitch is shorter than the debounce window.
        btn_up = 1'b1;
        ticks(2);
        btn_up = 1'b0;
        ticks(12);
        chk("glitch_dir", 32'(dir), 32'd0);
        chk("glitch_cnt", 32'(cnt), 32'd0);

        // 2. Button held 10 clocks from edge N. dir changes at N+6.
        //    Count steps at N+10 and N+14.
        w0     = wrap_seen;
        btn_up = 1'b1;
        ticks(6);
        chk("up_dir_N5", 32'(dir), 32'd0);
        ticks(1);
        chk("up_dir_N6", 32'(dir), 32'd2);
        ticks(3);
        chk("up_cnt_N9", 32'(cnt), 32'd0);
        btn_up = 1'b0;
        ticks(1);
        chk("up_cnt_N10", 32'(cnt), 32'd1);
        ticks(3);
        chk("up_cnt_N13", 32'(cnt), 32'd1);
        ticks(1);
        chk("up_cnt_N14", 32'(cnt), 32'd2);
        chk("up_nowrap", 32'(wrap_seen - w0), 32'd0);

        // Asynchronous reset between edges clears the count at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(cnt), 32'd0);
        chk("async_rst_dir", 32'(dir), 32'd0);
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // 5. DOWN from 0. The FSM moves at edge D. Steps follow at D+4 and D+8.
        w0       = wrap_seen;
        btn_down = 1'b1;
        ticks(7);
        chk("dn_dir_D", 32'(dir), 32'd1);
        chk("dn_cnt_D", 32'(cnt), 32'd0);
        btn_down = 1'b0;
        ticks(3);
        chk("dn_cnt_D3", 32'(cnt), 32'd0);
        chk("dn_wrap_D3", 32'(wrap), 32'd0);
        ticks(1);
        chk("dn_cnt_D4", 32'(cnt), 32'd99);
        chk("dn_wrap_D4", 32'(wrap), 32'd1);
        chk("dn_led_D4", 32'(led), 32'd1);
        // Set up here so the FSM moves to UP at D+11, between steps.
        btn_up = 1'b1;
        ticks(1);
        chk("dn_wrap_D5", 32'(wrap), 32'd0);
        ticks(3);
        chk("dn_cnt_D8", 32'(cnt), 32'd98);
        chk("dn_dir_D8", 32'(dir), 32'd1);

        // 4. Switch to UP with the count at 98. It steps at D+15 and D+19.
        ticks(3);
        chk("up98_dir_D11", 32'(dir), 32'd2);
        chk("up98_cnt_D11", 32'(cnt), 32'd98);
        btn_up = 1'b0;
        ticks(3);
        chk("up98_cnt_D14", 32'(cnt), 32'd98);
        ticks(1);
        chk("up98_cnt_D15", 32'(cnt), 32'd99);
        chk("up98_wrap_D15", 32'(wrap), 32'd0);
        ticks(3);
        chk("up98_cnt_D18", 32'(cnt), 32'd99);
        ticks(1);
        chk("up98_cnt_D19", 32'(cnt), 32'd0);
        chk("up98_wrap_D19", 32'(wrap), 32'd1);
        chk("up98_led_D19", 32'(led), 32'd0);
        ticks(1);
        chk("up98_wrap_D20", 32'(wrap), 32'd0);
        chk("wrap_pulses", 32'(wrap_seen - w0), 32'd2);

        // 6. Stop and up together after D+21. Steps come at D+23 and D+27.
        //    STOP wins at D+28.
        ticks(1);
        btn_stop = 1'b1;
        btn_up   = 1'b1;
        ticks(2);
        chk("su_cnt_D23", 32'(cnt), 32'd1);
        ticks(4);
        chk("su_cnt_D27", 32'(cnt), 32'd2);
        chk("su_dir_D27", 32'(dir), 32'd2);
        ticks(1);
        chk("su_dir_D28", 32'(dir), 32'd0);
        btn_stop = 1'b0;
        btn_up   = 1'b0;
        w0       = wrap_seen;
        ticks(20);
        chk("frozen_cnt", 32'(cnt), 32'd2);
        chk("frozen_dir", 32'(dir), 32'd0);
        chk("frozen_wrap", 32'(wrap_seen - w0), 32'd0);

        // Restart UP, then reset partway through a period.
        btn_up = 1'b1;
        ticks(7);
        chk("re_up_dir", 32'(dir), 32'd2);
        btn_up = 1'b0;
        ticks(4);
        chk("re_up_cnt", 32'(cnt), 32'd3);
        ticks(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_dir", 32'(dir), 32'd0);
        chk("mid_rst_wrap", 32'(wrap), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        chk("post_rst", 32'({cnt, dir, wrap, led}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
